// File: rtl/lighthouse_pkg.sv
// Shared types and the sync pulse decoder for the lighthouse sensor array.
package lighthouse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S0   = 2'd1,
    ST_S1   = 2'd2
  } state_t;

  // Slot numbering: which sync pulse carried the sweep and which axis it was.
  localparam logic [1:0] SLOT_SYNC0_AXIS1 = 2'd0;
  localparam logic [1:0] SLOT_SYNC0_AXIS0 = 2'd1;
  localparam logic [1:0] SLOT_SYNC1_AXIS1 = 2'd2;
  localparam logic [1:0] SLOT_SYNC1_AXIS0 = 2'd3;

  typedef struct packed {
    logic skip;
    logic data;
    logic axis;
  } sync_bits_t;

  typedef struct packed {
    logic       valid;
    sync_bits_t bits;
  } sync_dec_t;

  // Map a sync length bucket onto its skip/data/axis bits and validity.
  function automatic sync_dec_t decode_sync(input logic [31:0] bucket,
                                            input logic [31:0] min_bucket);
    sync_dec_t  d;
    logic [2:0] t;
    t           = 3'(bucket - min_bucket);
    d.valid     = (bucket >= min_bucket) && (bucket <= min_bucket + 32'd7);
    d.bits.skip = t[2];
    d.bits.data = t[1];
    d.bits.axis = t[0];
    return d;
  endfunction

endpackage

// File: rtl/lighthouse_channel.sv
// One photodiode channel: synchroniser, pulse timing, sync FSM, angle and holding register.
module lighthouse_channel
  import lighthouse_pkg::*;
#(
  parameter int unsigned WIDTH                  = 24,
  parameter int unsigned ANGLE_WIDTH            = 20,
  parameter int unsigned CLOCKS_PER_MICROSECOND = 48,
  parameter int unsigned SWEEP_MAX_US           = 15,
  parameter int unsigned SYNC_SHIFT             = 9,
  parameter int unsigned SYNC_MIN_BUCKET        = 6,
  parameter int unsigned TIMEOUT_US             = 20000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   raw_pin,
  input  logic                   enable,
  input  logic [WIDTH-1:0]       counter,
  input  logic                   grant,
  output logic                   hold_valid,
  output logic [1:0]             hold_slot,
  output logic [ANGLE_WIDTH-1:0] hold_angle,
  output logic [1:0]             hold_ootx,
  output logic                   overflow,
  output logic                   sync_error
);

  localparam int unsigned SWEEP_CLKS   = SWEEP_MAX_US * CLOCKS_PER_MICROSECOND;
  localparam int unsigned TIMEOUT_CLKS = TIMEOUT_US * CLOCKS_PER_MICROSECOND;
  localparam int unsigned TO_W         = $clog2(TIMEOUT_CLKS + 1);

  logic [2:0]             sync_q;
  logic                   rise_c, fall_c;
  logic [WIDTH-1:0]       t_fall_q, len_c, t_sync1_q, angle_full_c;
  logic                   is_sweep_c, sweep_c, sync_ok_c, sync_bad_c, timeout_c;
  sync_dec_t              dec_c;
  sync_bits_t             sync0_q, sync1_q;
  logic [TO_W-1:0]        idle_cnt_q;
  state_t                 state_q, state_d;
  logic                   load_s0_c, load_s1_c, emit_c, bad_c;
  logic                   sample_ok_c, pair_err_c;
  logic [1:0]             slot_c;
  logic [ANGLE_WIDTH-1:0] angle_c;

  // Pin synchroniser; the pin idles high so reset preloads ones.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[1:0], raw_pin};
  end

  assign rise_c = enable & sync_q[1] & ~sync_q[2];
  assign fall_c = enable & ~sync_q[1] & sync_q[2];

  // Timestamp of the most recent falling edge.
  always_ff @(posedge clk) begin
    if (reset)       t_fall_q <= '0;
    else if (fall_c) t_fall_q <= counter;
  end

  assign len_c      = counter - t_fall_q;
  assign is_sweep_c = len_c < WIDTH'(SWEEP_CLKS);
  assign dec_c      = decode_sync(32'(len_c >> SYNC_SHIFT), 32'(SYNC_MIN_BUCKET));
  assign sweep_c    = rise_c & is_sweep_c;
  assign sync_ok_c  = rise_c & ~is_sweep_c & dec_c.valid;
  assign sync_bad_c = rise_c & ~is_sweep_c & ~dec_c.valid;
  assign timeout_c  = (state_q != ST_IDLE) && !rise_c && !fall_c &&
                      (idle_cnt_q == TO_W'(TIMEOUT_CLKS - 1));

  // Cycles since the last edge while a sync sequence is in progress.
  always_ff @(posedge clk) begin
    if (reset || !enable || rise_c || fall_c || state_q == ST_IDLE)
      idle_cnt_q <= '0;
    else if (idle_cnt_q != TO_W'(TIMEOUT_CLKS - 1))
      idle_cnt_q <= idle_cnt_q + TO_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and per-cycle actions.
  always_comb begin
    state_d   = state_q;
    load_s0_c = 1'b0;
    load_s1_c = 1'b0;
    emit_c    = 1'b0;
    bad_c     = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (sync_bad_c) begin
      state_d = ST_IDLE;
      bad_c   = 1'b1;
    end else if (timeout_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (sync_ok_c) begin
          load_s0_c = 1'b1;
          state_d   = ST_S0;
        end
        ST_S0: if (sync_ok_c) begin
          load_s1_c = 1'b1;
          state_d   = ST_S1;
        end else if (sweep_c) begin
          state_d = ST_IDLE;
        end
        ST_S1: if (sweep_c) begin
          emit_c  = 1'b1;
          state_d = ST_IDLE;
        end else if (sync_ok_c) begin
          load_s0_c = 1'b1;
          state_d   = ST_S0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Decoded sync pulses and the sync1 reference time.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0_q   <= '0;
      sync1_q   <= '0;
      t_sync1_q <= '0;
    end else begin
      if (load_s0_c) sync0_q <= dec_c.bits;
      if (load_s1_c) begin
        sync1_q   <= dec_c.bits;
        t_sync1_q <= counter;
      end
    end
  end

  // Exactly one of the two syncs must be a skip for the sample to be usable.
  assign sample_ok_c = emit_c & (sync0_q.skip ^ sync1_q.skip);
  assign pair_err_c  = emit_c & ~(sync0_q.skip ^ sync1_q.skip);

  // Slot from whichever sync was not skipped.
  always_comb begin
    slot_c = SLOT_SYNC0_AXIS1;
    if (!sync0_q.skip) slot_c = sync0_q.axis ? SLOT_SYNC0_AXIS1 : SLOT_SYNC0_AXIS0;
    else               slot_c = sync1_q.axis ? SLOT_SYNC1_AXIS1 : SLOT_SYNC1_AXIS0;
  end

  // Angle from sync1 rise to sweep midpoint, saturating at the output width.
  assign angle_full_c = counter - (len_c >> 1) - t_sync1_q;
  generate
    if (ANGLE_WIDTH >= WIDTH) begin : g_nosat
      assign angle_c = ANGLE_WIDTH'(angle_full_c);
    end else begin : g_sat
      assign angle_c = ((angle_full_c >> ANGLE_WIDTH) != '0) ? '1 : ANGLE_WIDTH'(angle_full_c);
    end
  endgenerate

  // Sync error pulse.
  always_ff @(posedge clk) begin
    if (reset) sync_error <= 1'b0;
    else       sync_error <= bad_c | pair_err_c;
  end

  // Single-entry holding register; a full, undrained register drops the new sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_slot  <= '0;
      hold_angle <= '0;
      hold_ootx  <= '0;
      overflow   <= 1'b0;
    end else if (sample_ok_c) begin
      if (hold_valid && !grant) begin
        overflow <= 1'b1;
      end else begin
        hold_valid <= 1'b1;
        hold_slot  <= slot_c;
        hold_angle <= angle_c;
        hold_ootx  <= {sync1_q.data, sync0_q.data};
      end
    end else if (grant) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lighthouse_sensor_array.sv
// Multi-channel lighthouse front end: shared timestamp, round-robin merge, output register.
module lighthouse_sensor_array
  import lighthouse_pkg::*;
#(
  parameter int unsigned NUM_SENSORS            = 4,
  parameter int unsigned WIDTH                  = 24,
  parameter int unsigned ANGLE_WIDTH            = 20,
  parameter int unsigned CLOCKS_PER_MICROSECOND = 48,
  parameter int unsigned SWEEP_MAX_US           = 15,
  parameter int unsigned SYNC_SHIFT             = 9,
  parameter int unsigned SYNC_MIN_BUCKET        = 6,
  parameter int unsigned TIMEOUT_US             = 20000,
  localparam int unsigned SW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] raw_pin,
  input  logic [NUM_SENSORS-1:0] enable,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SW-1:0]          out_sensor,
  output logic [1:0]             out_slot,
  output logic [ANGLE_WIDTH-1:0] out_angle,
  output logic [1:0]             out_ootx,
  output logic [NUM_SENSORS-1:0] overflow,
  output logic [NUM_SENSORS-1:0] sync_error
);

  logic [WIDTH-1:0]       counter_q;
  logic [NUM_SENSORS-1:0] hold_valid, gnt_c;
  logic [1:0]             hold_slot  [NUM_SENSORS];
  logic [ANGLE_WIDTH-1:0] hold_angle [NUM_SENSORS];
  logic [1:0]             hold_ootx  [NUM_SENSORS];
  logic [SW-1:0]          ptr_q, gnt_idx_c;
  logic                   found_c, load_c;
  int unsigned            idx_c;

  // Free-running timestamp shared by all channels.
  always_ff @(posedge clk) begin
    if (reset) counter_q <= '0;
    else       counter_q <= counter_q + WIDTH'(1);
  end

  generate
    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_ch
      lighthouse_channel #(
        .WIDTH                 (WIDTH),
        .ANGLE_WIDTH           (ANGLE_WIDTH),
        .CLOCKS_PER_MICROSECOND(CLOCKS_PER_MICROSECOND),
        .SWEEP_MAX_US          (SWEEP_MAX_US),
        .SYNC_SHIFT            (SYNC_SHIFT),
        .SYNC_MIN_BUCKET       (SYNC_MIN_BUCKET),
        .TIMEOUT_US            (TIMEOUT_US)
      ) u_ch (
        .clk       (clk),
        .reset     (reset),
        .raw_pin   (raw_pin[g]),
        .enable    (enable[g]),
        .counter   (counter_q),
        .grant     (gnt_c[g]),
        .hold_valid(hold_valid[g]),
        .hold_slot (hold_slot[g]),
        .hold_angle(hold_angle[g]),
        .hold_ootx (hold_ootx[g]),
        .overflow  (overflow[g]),
        .sync_error(sync_error[g])
      );
    end
  endgenerate

  assign load_c = !out_valid || out_ready;

  // Round-robin pick starting at the pointer; grants only when the output can load.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    found_c   = 1'b0;
    idx_c     = 0;
    for (int unsigned k = 0; k < NUM_SENSORS; k++) begin
      idx_c = 32'(ptr_q) + k;
      if (idx_c >= NUM_SENSORS) idx_c = idx_c - NUM_SENSORS;
      if (!found_c && hold_valid[SW'(idx_c)]) begin
        found_c   = 1'b1;
        gnt_idx_c = SW'(idx_c);
      end
    end
    if (found_c && load_c) gnt_c[gnt_idx_c] = 1'b1;
  end

  // Output register and arbiter pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_sensor <= '0;
      out_slot   <= '0;
      out_angle  <= '0;
      out_ootx   <= '0;
      ptr_q      <= '0;
    end else if (load_c) begin
      out_valid <= found_c;
      if (found_c) begin
        out_sensor <= gnt_idx_c;
        out_slot   <= hold_slot[gnt_idx_c];
        out_angle  <= hold_angle[gnt_idx_c];
        out_ootx   <= hold_ootx[gnt_idx_c];
        ptr_q      <= (gnt_idx_c == SW'(NUM_SENSORS - 1)) ? '0 : gnt_idx_c + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_lighthouse_sensor_array.sv
// Directed bench for lighthouse_sensor_array with scaled-down timing parameters.
module tb_lighthouse_sensor_array;

  localparam int unsigned N   = 4;
  localparam int unsigned W   = 14;
  localparam int unsigned AW  = 10;
  localparam int unsigned CPU = 4;    // sweep < 60 clk, timeout 2000 clk
  localparam int unsigned SSH = 5;    // bucket = 32 clk

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   raw_pin, enable, overflow, sync_error;
  logic           out_valid, out_ready;
  logic [1:0]     out_sensor, out_slot, out_ootx;
  logic [AW-1:0]  out_angle;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int err_cnt [N];
  int q_sensor[$], q_slot[$], q_angle[$], q_ootx[$], q_cyc[$];
  int e0, e1;

  lighthouse_sensor_array #(
    .NUM_SENSORS(N), .WIDTH(W), .ANGLE_WIDTH(AW), .CLOCKS_PER_MICROSECOND(CPU),
    .SWEEP_MAX_US(15), .SYNC_SHIFT(SSH), .SYNC_MIN_BUCKET(6), .TIMEOUT_US(500)
  ) dut (
    .clk(clk), .reset(reset), .raw_pin(raw_pin), .enable(enable),
    .out_valid(out_valid), .out_ready(out_ready), .out_sensor(out_sensor),
    .out_slot(out_slot), .out_angle(out_angle), .out_ootx(out_ootx),
    .overflow(overflow), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  // Capture handshakes and sync error pulses away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) begin
      q_sensor.push_back(int'(out_sensor));
      q_slot.push_back(int'(out_slot));
      q_angle.push_back(int'(out_angle));
      q_ootx.push_back(int'(out_ootx));
      q_cyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) err_cnt[i] <= err_cnt[i] + int'(sync_error[i]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic low(input logic [N-1:0] m, input int len);
    raw_pin = raw_pin & ~m;
    tick(len);
    raw_pin = raw_pin | m;
  endtask

  function automatic int blen(input int b);
    return b * 32 + 16;
  endfunction

  // sync0, sync1, then a sweep falling d clk after sync1 rise and low for l clk.
  task automatic send(input logic [N-1:0] m, input int b0, input int b1, input int d, input int l);
    low(m, blen(b0));
    tick(100);
    low(m, blen(b1));
    tick(d);
    low(m, l);
    tick(50);
  endtask

  task automatic expect_sample(input string tag, input int s, input int sl, input int a, input int o);
    check({tag, "_present"}, 32'(q_sensor.size() > 0), 32'd1);
    if (q_sensor.size() > 0) begin
      check({tag, "_sensor"}, 32'(q_sensor.pop_front()), 32'(s));
      check({tag, "_slot"},   32'(q_slot.pop_front()),   32'(sl));
      check({tag, "_angle"},  32'(q_angle.pop_front()),  32'(a));
      check({tag, "_ootx"},   32'(q_ootx.pop_front()),   32'(o));
      void'(q_cyc.pop_front());
    end
  endtask

  initial begin
    int exp_a[4];
    int exp_b[3];
    int c0;
    for (int i = 0; i < N; i++) err_cnt[i] = 0;
    reset = 1'b1; raw_pin = '1; enable = '0; out_ready = 1'b0;
    tick(5);
    check("rst_valid",    32'(out_valid),  32'd0);
    check("rst_sensor",   32'(out_sensor), 32'd0);
    check("rst_slot",     32'(out_slot),   32'd0);
    check("rst_angle",    32'(out_angle),  32'd0);
    check("rst_ootx",     32'(out_ootx),   32'd0);
    check("rst_overflow", 32'(overflow),   32'd0);
    check("rst_syncerr",  32'(sync_error), 32'd0);
    reset = 1'b0; enable = '1; out_ready = 1'b1;
    tick(5);

    // Basic decode: slot 1, slot 2, slot 3, and data bits.
    send(4'b0001, 6, 10, 500, 40);  expect_sample("t1", 0, 1, 520, 0);
    send(4'b0001, 10, 7, 280, 40);  expect_sample("t2", 0, 2, 300, 0);
    send(4'b0001, 10, 8, 60, 44);   expect_sample("t2b", 0, 3, 82, 2);
    send(4'b0001, 9, 12, 100, 20);  expect_sample("t2c", 0, 0, 110, 3);
    check("t2_no_err", 32'(err_cnt[0]), 32'd0);

    // Both skip bits equal: dropped with one error pulse.
    e0 = err_cnt[0];
    send(4'b0001, 6, 6, 200, 40);
    check("t3_no_out", 32'(q_sensor.size()), 32'd0);
    check("t3_err",    32'(err_cnt[0] - e0), 32'd1);
    // Out-of-range sync from S1 aborts the sequence.
    e0 = err_cnt[0];
    low(4'b0001, blen(6)); tick(100);
    low(4'b0001, blen(7)); tick(100);
    low(4'b0001, 528);     tick(100);
    low(4'b0001, 40);      tick(50);
    check("t3_bad_no_out", 32'(q_sensor.size()), 32'd0);
    check("t3_bad_err",    32'(err_cnt[0] - e0), 32'd1);

    // Simultaneous emission on all channels; pointer sits at 1 after ch0 grants.
    exp_a = '{1, 2, 3, 0};
    send(4'b1111, 6, 10, 500, 40);
    check("t4_count", 32'(q_sensor.size()), 32'd4);
    c0 = (q_cyc.size() > 0) ? q_cyc[0] : 0;
    for (int k = 0; k < 4; k++) begin
      if (q_cyc.size() > 0) check("t4_consec", 32'(q_cyc[0] - c0), 32'(k));
      expect_sample("t4", exp_a[k], 1, 520, 0);
    end
    send(4'b0010, 6, 10, 100, 40);  expect_sample("t4_ch1", 1, 1, 120, 0);
    enable = 4'b0111;
    exp_b = '{2, 0, 1};
    send(4'b1111, 6, 10, 100, 40);
    check("t4b_count", 32'(q_sensor.size()), 32'd3);
    for (int k = 0; k < 3; k++) expect_sample("t4b", exp_b[k], 1, 120, 0);
    enable = 4'b1111;

    // Backpressure: first held stable, second waits in holding, third dropped.
    out_ready = 1'b0;
    send(4'b0100, 6, 10, 100, 40);
    check("t5_valid",  32'(out_valid),  32'd1);
    check("t5_sensor", 32'(out_sensor), 32'd2);
    check("t5_angle",  32'(out_angle),  32'd120);
    send(4'b0100, 6, 10, 200, 40);
    check("t5_no_ovf",  32'(overflow),  32'd0);
    check("t5_stable1", 32'(out_angle), 32'd120);
    send(4'b0100, 6, 10, 300, 40);
    check("t5_ovf",     32'(overflow),  32'b0100);
    check("t5_stable2", 32'(out_angle), 32'd120);
    check("t5_valid2",  32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick(10);
    check("t5_count", 32'(q_sensor.size()), 32'd2);
    expect_sample("t5a", 2, 1, 120, 0);
    expect_sample("t5b", 2, 1, 220, 0);
    check("t5_sticky", 32'(overflow), 32'b0100);

    // Timeout from S1 returns to IDLE quietly.
    e1 = err_cnt[1];
    low(4'b0010, blen(6)); tick(100);
    low(4'b0010, blen(10));
    tick(2100);
    low(4'b0010, 40); tick(50);
    check("t6_timeout_no_out", 32'(q_sensor.size()), 32'd0);
    check("t6_timeout_no_err", 32'(err_cnt[1] - e1), 32'd0);
    // Saturation boundary.
    send(4'b0010, 6, 10, 1002, 40); expect_sample("t6_1022", 1, 1, 1022, 0);
    send(4'b0010, 6, 10, 1004, 40); expect_sample("t6_sat",  1, 1, 1023, 0);
    send(4'b0010, 6, 10, 1480, 40); expect_sample("t6_sat2", 1, 1, 1023, 0);

    // Reset with samples in flight.
    out_ready = 1'b0;
    send(4'b0001, 6, 10, 100, 40);
    send(4'b0001, 6, 10, 200, 40);
    check("t7_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick(1);
    check("t7_valid_drop", 32'(out_valid), 32'd0);
    check("t7_ovf_clear",  32'(overflow),  32'd0);
    reset = 1'b0;
    tick(5);
    out_ready = 1'b1;
    tick(10);
    check("t7_discard", 32'(q_sensor.size()), 32'd0);
    send(4'b0001, 9, 12, 100, 20);  expect_sample("t7_after", 0, 0, 110, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
